// File: rtl/rotator_arbiter.sv
// Round-robin arbiter sharing one 64-bit left rotator among NUM_REQ requesters.
// The rotated result is registered and returned with the winner's index.
module rotator_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*64-1:0] req_data_i,
  input  logic [NUM_REQ*6-1:0]  req_rot_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  rsp_valid_o,
  output logic [63:0]           rsp_data_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id_o,
  input  logic                  rsp_ready_i
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            any_valid;
  logic            out_free;
  logic            accept;
  logic [63:0]     sel_data;
  logic [5:0]      sel_rot;
  logic [63:0]     r5, r4, r3, r2, r1, r0;

  // Scan upward from rr_ptr, wrapping; first valid requester wins.
  always_comb begin
    int  idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign any_valid = |req_valid_i;
  assign out_free  = !rsp_valid_o || rsp_ready_i;
  assign accept    = any_valid && out_free;

  always_comb begin
    req_ready_o = '0;
    if (accept && rst_ni) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    sel_rot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_data = req_data_i[64*i +: 64];
        sel_rot  = req_rot_i[6*i +: 6];
      end
    end
  end

  assign r5 = sel_rot[5] ? {sel_data[31:0], sel_data[63:32]} : sel_data;
  assign r4 = sel_rot[4] ? {r5[47:0], r5[63:48]} : r5;
  assign r3 = sel_rot[3] ? {r4[55:0], r4[63:56]} : r4;
  assign r2 = sel_rot[2] ? {r3[59:0], r3[63:60]} : r3;
  assign r1 = sel_rot[1] ? {r2[61:0], r2[63:62]} : r2;
  assign r0 = sel_rot[0] ? {r1[62:0], r1[63]} : r1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= r0;
      rsp_id_o    <= grant_idx;
      if (grant_idx == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                 rr_ptr <= grant_idx + ID_W'(1);
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotator_arbiter.sv
// Directed bench for rotator_arbiter: rotation values, round-robin order,
// back-pressure, pointer wrap and asynchronous reset.
module tb_rotator_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [23:0]  req_rot;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [63:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_ready;

  int checks = 0;
  int errors = 0;

  rotator_arbiter #(.NUM_REQ(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_rot_i   (req_rot),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_ready_i (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] d, input logic [5:0] r);
    req_data[64*i +: 64] = d;
    req_rot[6*i +: 6]    = r;
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] d, input int r);
    if (r == 0) return d;
    return (d << r) | (d >> (64 - r));
  endfunction

  logic [63:0] stall_data;
  int          exp_id;

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    req_rot   = '0;
    rsp_ready = 1'b1;
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_req_ready", req_ready, 0);
    req_valid = 4'h0;
    #12 rst_n = 1'b1;
    step();

    // Basic rotate from requester 0
    set_req(0, 64'h0123456789ABCDEF, 6'd4);
    req_valid = 4'b0001;
    #1 check("t1_ready", req_ready, 4'b0001);
    step();
    check("t1_valid", rsp_valid, 1);
    check("t1_data", rsp_data, 64'h123456789ABCDEF0);
    check("t1_id", rsp_id, 0);

    // Requester 1 boundary rotates (rr_ptr=1 then 2; req1 still wins)
    req_valid = 4'b0010;
    set_req(1, 64'h8000000000000001, 6'd1);
    #1 check("t2_ready_r1", req_ready, 4'b0010);
    step();
    check("t2_data_r1", rsp_data, 64'h0000000000000003);
    check("t2_id_r1", rsp_id, 1);
    set_req(1, 64'h8000000000000001, 6'd63);
    step();
    check("t2_data_r63", rsp_data, 64'hC000000000000000);
    set_req(1, 64'h8000000000000001, 6'd0);
    step();
    check("t2_data_r0", rsp_data, 64'h8000000000000001);
    check("t2_valid", rsp_valid, 1);

    // Grant to 3 sets rr_ptr=0, then all four back-to-back
    req_valid = 4'b1000;
    set_req(3, 64'hFEDCBA9876543210, 6'd12);
    #1 check("t3_pre_ready", req_ready, 4'b1000);
    step();
    check("t3_pre_id", rsp_id, 3);
    check("t3_pre_data", rsp_data, 64'hCBA9876543210FED);
    set_req(0, 64'h0123456789ABCDEF, 6'd8);
    set_req(1, 64'hA5A5A5A5F0F0F0F0, 6'd17);
    set_req(2, 64'h0000000000000001, 6'd63);
    set_req(3, 64'hDEADBEEFCAFEF00D, 6'd32);
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      exp_id = n % 4;
      #1 check($sformatf("t3_ready_%0d", n), req_ready, 4'b0001 << exp_id);
      step();
      check($sformatf("t3_valid_%0d", n), rsp_valid, 1);
      check($sformatf("t3_id_%0d", n), rsp_id, exp_id);
      check($sformatf("t3_data_%0d", n), rsp_data,
            rotl(req_data[64*exp_id +: 64], int'(req_rot[6*exp_id +: 6])));
    end
    check("t3_hand_r0", rotl(64'h0123456789ABCDEF, 8), 64'h23456789ABCDEF01);

    // Back-pressure: last response id3 must hold for 5 cycles
    stall_data = rsp_data;
    rsp_ready  = 1'b0;
    #1 check("t4_ready_blocked", req_ready, 0);
    for (int n = 0; n < 5; n++) begin
      step();
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_id", rsp_id, 3);
      check("t4_hold_data", rsp_data, stall_data);
      check("t4_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1 check("t4_release_ready", req_ready, 4'b0001);
    step();
    check("t4_release_id", rsp_id, 0);
    check("t4_release_data", rsp_data, 64'h23456789ABCDEF01);

    // Pointer wrap (rr_ptr=1 now)
    req_valid = 4'b1000;
    step();
    check("t5_id3", rsp_id, 3);
    req_valid = 4'b0100;
    #1 check("t5_ready2", req_ready, 4'b0100);
    step();
    check("t5_id2", rsp_id, 2);
    req_valid = 4'b0101;
    #1 check("t5_ready_wrap", req_ready, 4'b0001);
    step();
    check("t5_id_wrap", rsp_id, 0);

    // Idle cycles drop valid, hold data/id, and do not move rr_ptr (=1)
    req_valid = 4'b0000;
    stall_data = rsp_data;
    step();
    check("idle_valid", rsp_valid, 0);
    check("idle_data", rsp_data, stall_data);
    check("idle_id", rsp_id, 0);
    step();
    req_valid = 4'b0110;
    #1 check("idle_ptr_ready", req_ready, 4'b0010);
    step();
    check("idle_ptr_id", rsp_id, 1);
    check("idle_ptr_valid", rsp_valid, 1);

    // Async reset with response pending and rr_ptr=2
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", rsp_valid, 0);
    check("t6_rst_data", rsp_data, 0);
    check("t6_rst_id", rsp_id, 0);
    check("t6_rst_ready", req_ready, 0);
    req_valid = 4'b1010;
    #3 rst_n = 1'b1;
    #1 check("t6_first_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    check("t6_first_id", rsp_id, 1);
    check("t6_first_valid", rsp_valid, 1);
    req_valid = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
